pipelined_adder_tree: RTL and testbench

PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

---
 rtl/pipelined_adder_tree.sv | 182 ++++++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//   Sums N_INPUTS operands per beat through a registered binary adder tree
//   (D = clog2(N_INPUTS) levels), then accumulates tree sums across a
//   first..last group of beats. The group result appears D+1 cycles after
//   the last beat.
//
//   Optional feature: define ADDER_TREE_ACC_SAT_EN to clamp every accumulator
//   add to the ACC_WIDTH range and report it on dout_sat. Without it the
//   accumulator wraps and dout_sat is tied low.
//
// Ports
//   clk, rst_n       : clock (rising edge), async active-low reset
//   din_valid        : beat strobe
//   din_first/last   : group framing, qualified by din_valid
//   din              : N_INPUTS operands, operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid       : one-cycle pulse per completed group
//   dout, dout_sat   : group sum and clamp flag, held until next dout_valid
//   seq_err          : one-cycle pulse on a framing violation
module pipelined_adder_tree #(
  parameter int N_INPUTS   = 37,
  parameter int DATA_WIDTH = 8,
  parameter int SIGNED     = 0,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           din_valid,
  input  logic                           din_first,
  input  logic                           din_last,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] din,
  output logic                           dout_valid,
  output logic [ACC_WIDTH-1:0]           dout,
  output logic                           dout_sat,
  output logic                           seq_err
);
  localparam int D          = $clog2(N_INPUTS);
  localparam int TREE_WIDTH = DATA_WIDTH + D;

  // operand count at tree level l
  function automatic int cnt(input int l);
    return (N_INPUTS + (1 << l) - 1) >> l;
  endfunction

  // ---------------- adder tree ----------------
  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int W = DATA_WIDTH + l;
    localparam int C = cnt(l);
    logic [C-1:0][W-1:0] w_opnd;

    if (l == 0) begin : g_in
      assign w_opnd = din;
    end else begin : g_add
      localparam int PC = cnt(l - 1);
      logic [C-1:0][W-1:0] w_sum;
      logic [C-1:0][W-1:0] r_sum;

      for (genvar k = 0; k < C; k++) begin : g_node
        logic [W-1:0] w_a, w_b;
        assign w_a = {(SIGNED != 0) & g_lvl[l-1].w_opnd[2*k][W-2], g_lvl[l-1].w_opnd[2*k]};
        if (2*k + 1 < PC) begin : g_pair
          assign w_b = {(SIGNED != 0) & g_lvl[l-1].w_opnd[2*k+1][W-2], g_lvl[l-1].w_opnd[2*k+1]};
        end else begin : g_odd
          // leftover operand rides through extended so levels stay aligned
          assign w_b = '0;
        end
        assign w_sum[k] = w_a + w_b;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sum <= '0;
        else        r_sum <= w_sum;
      end
      assign w_opnd = r_sum;
    end
  end

  // framing travels alongside the tree data
  logic [D:1] r_vld, r_first, r_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_first <= '0;
      r_last  <= '0;
    end else begin
      r_vld[1]   <= din_valid;
      r_first[1] <= din_first;
      r_last[1]  <= din_last;
      for (int i = 2; i <= D; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_first[i] <= r_first[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  // ---------------- accumulator ----------------
  logic [TREE_WIDTH-1:0] w_tree;
  logic [ACC_WIDTH-1:0]  w_ext;
  assign w_tree = g_lvl[D].w_opnd[0];
  if (SIGNED != 0) begin : g_sext
    assign w_ext = ACC_WIDTH'($signed(w_tree));
  end else begin : g_zext
    assign w_ext = ACC_WIDTH'(w_tree);
  end

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc, r_dout, w_base, w_next;
  logic                 r_dout_valid, r_seq_err;
  logic                 w_beat, w_start, w_err;

  assign w_beat  = r_vld[D];
  // a beat in IDLE always opens a group, even without first
  assign w_start = r_first[D] | (r_state == IDLE);
  assign w_err   = (r_state == IDLE) ? ~r_first[D] : r_first[D];
  assign w_base  = w_start ? '0 : r_acc;

`ifdef ADDER_TREE_ACC_SAT_EN
  logic [ACC_WIDTH:0] w_full;
  logic               w_clamp, w_sat_grp, r_sat, r_dout_sat;

  always_comb begin
    w_full  = '0;
    w_clamp = 1'b0;
    w_next  = '0;
    if (SIGNED != 0) begin
      w_full  = {w_base[ACC_WIDTH-1], w_base} + {w_ext[ACC_WIDTH-1], w_ext};
      w_clamp = w_full[ACC_WIDTH] ^ w_full[ACC_WIDTH-1];
      if (!w_clamp)              w_next = w_full[ACC_WIDTH-1:0];
      else if (w_full[ACC_WIDTH]) w_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                        w_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      w_full  = {1'b0, w_base} + {1'b0, w_ext};
      w_clamp = w_full[ACC_WIDTH];
      w_next  = w_clamp ? '1 : w_full[ACC_WIDTH-1:0];
    end
  end
  assign w_sat_grp = (w_start ? 1'b0 : r_sat) | w_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat      <= 1'b0;
      r_dout_sat <= 1'b0;
    end else if (w_beat) begin
      r_sat <= w_sat_grp;
      if (r_last[D]) r_dout_sat <= w_sat_grp;
    end
  end
  assign dout_sat = r_dout_sat;
`else
  assign w_next   = w_base + w_ext;
  assign dout_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_seq_err    <= 1'b0;
      if (w_beat) begin
        r_acc     <= w_next;
        r_seq_err <= w_err;
        if (r_last[D]) begin
          r_state      <= IDLE;
          r_dout       <= w_next;
          r_dout_valid <= 1'b1;
        end else begin
          r_state <= ACCUM;
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign seq_err    = r_seq_err;
endmodule

// File: tb/tb_pipelined_adder_tree.sv
module tb_pipelined_adder_tree;
  localparam int N   = 37;
  localparam int DW  = 8;
  localparam int LAT = 7;            // D+1 for N=37
  localparam int VW  = N * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    vld, fst, lst;
  logic [VW-1:0] din [3];
  logic          dv0, dv1, dv2, sat0, sat1, sat2, se0, se1, se2;
  logic [23:0]   d0, d1;
  logic [13:0]   d2;

  // u0: unsigned acc24, u1: signed acc24, u2: unsigned acc14
  pipelined_adder_tree #(.N_INPUTS(N), .DATA_WIDTH(DW), .SIGNED(0), .ACC_WIDTH(24)) u0 (
    .clk(clk), .rst_n(rst_n), .din_valid(vld[0]), .din_first(fst[0]), .din_last(lst[0]),
    .din(din[0]), .dout_valid(dv0), .dout(d0), .dout_sat(sat0), .seq_err(se0));
  pipelined_adder_tree #(.N_INPUTS(N), .DATA_WIDTH(DW), .SIGNED(1), .ACC_WIDTH(24)) u1 (
    .clk(clk), .rst_n(rst_n), .din_valid(vld[1]), .din_first(fst[1]), .din_last(lst[1]),
    .din(din[1]), .dout_valid(dv1), .dout(d1), .dout_sat(sat1), .seq_err(se1));
  pipelined_adder_tree #(.N_INPUTS(N), .DATA_WIDTH(DW), .SIGNED(0), .ACC_WIDTH(14)) u2 (
    .clk(clk), .rst_n(rst_n), .din_valid(vld[2]), .din_first(fst[2]), .din_last(lst[2]),
    .din(din[2]), .dout_valid(dv2), .dout(d2), .dout_sat(sat2), .seq_err(se2));

  typedef struct {int id; int cyc; logic [23:0] val; logic sat;} res_t;
  typedef struct {int id; int cyc;} se_t;
  res_t rq[$];
  se_t  sq[$];

  int cyc = 0;
  int bc  = 0;
  int nchk = 0, nerr = 0;
`ifdef ADDER_TREE_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int id, input logic v, input logic [23:0] d,
                     input logic s, input logic e);
    res_t r;
    se_t  q;
    if (v) begin
      if (rq.size() == 0) chk($sformatf("dut%0d stray dout_valid @%0d", id, cyc), 32'(v), 0);
      else begin
        r = rq.pop_front();
        chk($sformatf("dut%0d result id", id), id, r.id);
        chk($sformatf("dut%0d dout_valid cycle", id), cyc, r.cyc);
        chk($sformatf("dut%0d dout", id), {8'h0, d}, {8'h0, r.val});
        chk($sformatf("dut%0d dout_sat", id), 32'(s), 32'(r.sat));
      end
    end
    if (e) begin
      if (sq.size() == 0) chk($sformatf("dut%0d stray seq_err @%0d", id, cyc), 32'(e), 0);
      else begin
        q = sq.pop_front();
        chk($sformatf("dut%0d seq_err id", id), id, q.id);
        chk($sformatf("dut%0d seq_err cycle", id), cyc, q.cyc);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      mon(0, dv0, d0, sat0, se0);
      mon(1, dv1, d1, sat1, se1);
      mon(2, dv2, {10'h0, d2}, sat2, se2);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [VW-1:0] fill(input logic [7:0] v);
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  // operand k = k (unsigned sum 666), or k-18 when signed (sum 0)
  function automatic logic [VW-1:0] ramp(input bit sgn);
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = sgn ? 8'(k - 18) : 8'(k);
    return r;
  endfunction

  // even operands 127, odd -128: 19*127 - 18*128 = 109
  function automatic logic [VW-1:0] alt();
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = (k % 2 == 0) ? 8'h7F : 8'h80;
    return r;
  endfunction

  task automatic send(input int id, input logic f, input logic l, input logic [VW-1:0] data);
    @(negedge clk);
    vld = '0; fst = '0; lst = '0;
    vld[id] = 1'b1; fst[id] = f; lst[id] = l; din[id] = data;
    bc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = '0; fst = '0; lst = '0;
    end
  endtask

  task automatic exp_res(input int id, input logic [23:0] v, input logic s);
    rq.push_back('{id, bc + LAT, v, s});
  endtask

  task automatic exp_se(input int id);
    sq.push_back('{id, bc + LAT});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " dout0"}, {8'h0, d0}, 0);
    chk({nm, " dout1"}, {8'h0, d1}, 0);
    chk({nm, " dout2"}, {18'h0, d2}, 0);
    chk({nm, " valid"}, {29'h0, dv2, dv1, dv0}, 0);
    chk({nm, " seq_err"}, {29'h0, se2, se1, se0}, 0);
    chk({nm, " sat"}, {29'h0, sat2, sat1, sat0}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vld = '0; fst = '0; lst = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // framing violations: first=0 in IDLE opens group, first=1 mid-group restarts
    send(0, 1'b0, 1'b0, fill(8'd1)); exp_se(0);
    send(0, 1'b0, 1'b0, fill(8'd2));
    send(0, 1'b1, 1'b0, fill(8'd3)); exp_se(0);
    send(0, 1'b0, 1'b1, fill(8'd1)); exp_res(0, 24'd148, 1'b0);   // 111 + 37
    idle(10);

    send(0, 1'b1, 1'b1, fill(8'd255)); exp_res(0, 24'd9435, 1'b0); // 37*255
    send(0, 1'b1, 1'b1, ramp(1'b0));   exp_res(0, 24'd666, 1'b0);  // 0+..+36
    idle(10);

    send(1, 1'b1, 1'b1, fill(8'h80));  exp_res(1, 24'hFFED80, 1'b0); // -4736
    send(1, 1'b1, 1'b1, alt());        exp_res(1, 24'd109, 1'b0);
    send(1, 1'b1, 1'b1, ramp(1'b1));   exp_res(1, 24'd0, 1'b0);
    // three-beat group with idle gaps inside
    send(1, 1'b1, 1'b0, fill(8'd1));
    idle(2);
    send(1, 1'b0, 1'b0, fill(8'd1));
    idle(1);
    send(1, 1'b0, 1'b1, fill(8'd1));   exp_res(1, 24'd111, 1'b0);
    idle(10);

    // 14-bit accumulator: 2*9435 = 18870 overflows
    send(2, 1'b1, 1'b0, fill(8'd255));
    send(2, 1'b0, 1'b1, fill(8'd255));
    if (SAT_EN) exp_res(2, 24'd16383, 1'b1);
    else        exp_res(2, 24'd2486, 1'b0);
    send(2, 1'b1, 1'b1, fill(8'd255)); exp_res(2, 24'd9435, 1'b0);
    idle(10);

    // back-to-back single-beat groups
    for (int i = 1; i <= 10; i++) begin
      send(0, 1'b1, 1'b1, fill(8'(i))); exp_res(0, 24'(37 * i), 1'b0);
    end
    idle(10);

    // stream then reset: groups 7..12 are still in flight and must vanish
    for (int i = 1; i <= 12; i++) begin
      send(0, 1'b1, 1'b1, fill(8'(i)));
      if (i <= 6) exp_res(0, 24'(37 * i), 1'b0);
    end
    @(negedge clk);
    vld = '0; fst = '0; lst = '0;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    idle(2);
    rst_n = 1'b1;
    idle(12);

    send(0, 1'b1, 1'b1, fill(8'd4)); exp_res(0, 24'd148, 1'b0);
    idle(20);

    chk("results outstanding", rq.size(), 0);
    chk("seq_err outstanding", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
